stopwatch_mmss: RTL and testbench

//   MM:SS stopwatch counting seconds off the 1 Hz square wave from the clock divider.

---
 rtl/stopwatch_mmss.sv | 148 ++++++++++++++
 tb/tb_stopwatch_mmss.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_mmss.sv
// stopwatch_mmss: MM:SS stopwatch stepped by rising edges of a 1 Hz square wave.
//
// Parameters:
//   MIN_LIMIT   - last displayed minute value (1..59)
//   STOP_AT_MAX - 0: wrap MIN_LIMIT:59 -> 00:00 and keep running
//                 1: hold at MIN_LIMIT:59 and pause
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   clk1hz              - 1 Hz square wave, synchronous to clk
//   start_stop          - pulse: toggle run/pause
//   clear               - pulse: back to 00:00 and idle
//   lap                 - pulse: toggle lap freeze of the display
//   sec_ones..min_tens  - displayed BCD digits
//   running             - high while counting is enabled
//   lap_active          - high while the display shows the lap snapshot
//   max_reached         - one-cycle pulse when the count hits/passes MIN_LIMIT:59
module stopwatch_mmss #(
    parameter int unsigned MIN_LIMIT   = 59,
    parameter bit          STOP_AT_MAX = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk1hz,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic       running,
    output logic       lap_active,
    output logic       max_reached
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    localparam logic [2:0] LIM_T = 3'(MIN_LIMIT / 10);
    localparam logic [3:0] LIM_O = 4'(MIN_LIMIT % 10);

    // Count and snapshot packed as {min_tens, min_ones, sec_tens, sec_ones}.
    logic [1:0]  state_q, state_d;
    logic [13:0] cnt_q, cnt_d, cnt_inc;
    logic [13:0] snap_q, snap_d;
    logic        lap_q, lap_d;
    logic        max_q, max_d;
    logic        clk1hz_q;

    logic       tick, count_en, at_max, lands;
    logic [3:0] c_so, c_mo;
    logic [2:0] c_st, c_mt;
    logic [13:0] disp;

    assign c_so = cnt_q[3:0];
    assign c_st = cnt_q[6:4];
    assign c_mo = cnt_q[10:7];
    assign c_mt = cnt_q[13:11];

    assign tick     = clk1hz & ~clk1hz_q;
    assign count_en = (state_q == RUN) && tick;
    assign at_max   = (c_mt == LIM_T) && (c_mo == LIM_O) && (c_st == 3'd5) && (c_so == 4'd9);
    // The next increment lands exactly on MIN_LIMIT:59.
    assign lands    = (c_mt == LIM_T) && (c_mo == LIM_O) && (c_st == 3'd5) && (c_so == 4'd8);

    // BCD increment with carry chain; wraps to 00:00 after MIN_LIMIT:59.
    always_comb begin
        cnt_inc = cnt_q;
        if (at_max) begin
            cnt_inc = '0;
        end else if (c_so != 4'd9) begin
            cnt_inc[3:0] = c_so + 4'd1;
        end else begin
            cnt_inc[3:0] = 4'd0;
            if (c_st != 3'd5) begin
                cnt_inc[6:4] = c_st + 3'd1;
            end else begin
                cnt_inc[6:4] = 3'd0;
                if (c_mo != 4'd9) begin
                    cnt_inc[10:7] = c_mo + 4'd1;
                end else begin
                    cnt_inc[10:7]  = 4'd0;
                    cnt_inc[13:11] = c_mt + 3'd1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        lap_d   = lap_q;
        max_d   = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            lap_d   = 1'b0;
        end else begin
            // Increment is qualified by the state before any transition this cycle.
            if (count_en) begin
                cnt_d = cnt_inc;
                max_d = at_max | (STOP_AT_MAX & lands);
            end
            if (start_stop) begin
                state_d = (state_q == RUN) ? PAUSE : RUN;
            end else if (STOP_AT_MAX && count_en && lands) begin
                state_d = PAUSE;
            end
            if (!start_stop && lap && (state_q != IDLE)) begin
                if (!lap_q) begin
                    lap_d  = 1'b1;
                    snap_d = cnt_d;
                end else begin
                    lap_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        clk1hz_q <= clk1hz;
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            lap_q   <= 1'b0;
            max_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            lap_q   <= lap_d;
            max_q   <= max_d;
        end
    end

    assign disp        = lap_q ? snap_q : cnt_q;
    assign sec_ones    = disp[3:0];
    assign sec_tens    = disp[6:4];
    assign min_ones    = disp[10:7];
    assign min_tens    = disp[13:11];
    assign running     = (state_q == RUN);
    assign lap_active  = lap_q;
    assign max_reached = max_q;

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Bench for stopwatch_mmss: two instances (wrap / stop-at-max) share stimulus and are
// compared every cycle against a seconds-based reference model, plus directed checks.
module tb_stopwatch_mmss;

    localparam int LIMIT = 59;
    localparam int TOP   = (LIMIT + 1) * 60 - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic c1hz = 1'b1;
    logic ss = 1'b0, clr = 1'b0, lp = 1'b0;

    logic [3:0] so0, mo0, so1, mo1;
    logic [2:0] st0, mt0, st1, mt1;
    logic run0, lap0, max0, run1, lap1, max1;

    int checks = 0;
    int failures = 0;

    // Reference model: count held as plain seconds; state 0 idle, 1 run, 2 pause.
    int m_st[2];
    int m_cnt[2];
    int m_snap[2];
    bit m_lap[2];
    bit m_max[2];
    bit m_prev;

    always #5 clk = ~clk;

    stopwatch_mmss #(.MIN_LIMIT(LIMIT), .STOP_AT_MAX(1'b0)) u0 (
        .clk(clk), .rst(rst), .clk1hz(c1hz), .start_stop(ss), .clear(clr), .lap(lp),
        .sec_ones(so0), .sec_tens(st0), .min_ones(mo0), .min_tens(mt0),
        .running(run0), .lap_active(lap0), .max_reached(max0)
    );

    stopwatch_mmss #(.MIN_LIMIT(LIMIT), .STOP_AT_MAX(1'b1)) u1 (
        .clk(clk), .rst(rst), .clk1hz(c1hz), .start_stop(ss), .clear(clr), .lap(lp),
        .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1),
        .running(run1), .lap_active(lap1), .max_reached(max1)
    );

    function automatic logic [13:0] bcd(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [13:0] disp(input int i);
        return (i == 0) ? {mt0, mo0, st0, so0} : {mt1, mo1, st1, so1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit tk;
        tk = c1hz && !m_prev;
        for (int i = 0; i < 2; i++) begin
            int pre, nc;
            bit mx, stop;
            stop = (i == 1);
            pre  = m_st[i];
            nc   = m_cnt[i];
            mx   = 1'b0;
            if (rst) begin
                m_st[i] = 0; m_cnt[i] = 0; m_snap[i] = 0; m_lap[i] = 0; m_max[i] = 0;
            end else if (clr) begin
                m_st[i] = 0; m_cnt[i] = 0; m_lap[i] = 0; m_max[i] = 0;
            end else begin
                if (pre == 1 && tk) begin
                    if (nc == TOP) begin
                        nc = 0; mx = 1'b1;
                    end else begin
                        nc = nc + 1;
                        if (stop && nc == TOP) mx = 1'b1;
                    end
                end
                m_cnt[i] = nc;
                m_max[i] = mx;
                if (ss) m_st[i] = (pre == 1) ? 2 : 1;
                else if (stop && mx && nc == TOP) m_st[i] = 2;
                if (!ss && lp && pre != 0) begin
                    if (!m_lap[i]) begin
                        m_lap[i] = 1'b1; m_snap[i] = nc;
                    end else begin
                        m_lap[i] = 1'b0;
                    end
                end
            end
        end
        m_prev = c1hz;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("disp0", disp(0), bcd(m_lap[0] ? m_snap[0] : m_cnt[0]));
        chk("run0", run0, m_st[0] == 1);
        chk("lap0", lap0, m_lap[0]);
        chk("max0", max0, m_max[0]);
        chk("disp1", disp(1), bcd(m_lap[1] ? m_snap[1] : m_cnt[1]));
        chk("run1", run1, m_st[1] == 1);
        chk("lap1", lap1, m_lap[1]);
        chk("max1", max1, m_max[1]);
    endtask

    task automatic tick();
        c1hz = 1'b1; cyc();
        c1hz = 1'b0; cyc();
    endtask

    initial begin
        m_prev = 1'b1;
        // Reset with clk1hz high, then release: no tick.
        repeat (3) cyc();
        rst = 1'b0;
        repeat (3) cyc();
        chk("rst_disp", disp(0), 14'd0);
        chk("rst_run", run0, 1'b0);
        chk("rst_max", max0, 1'b0);
        c1hz = 1'b0; cyc();
        chk("idle_no_count", disp(0), 14'd0);

        // Start and count 75 seconds.
        ss = 1'b1; cyc(); ss = 1'b0;
        repeat (74) tick();
        c1hz = 1'b1;
        chk("lat_before", disp(0), bcd(74));
        cyc();
        chk("lat_after", disp(0), bcd(75));
        c1hz = 1'b0; cyc();
        chk("m0115", disp(0), bcd(75));
        chk("m0115_run", run0, 1'b1);

        // Lap freeze.
        clr = 1'b1; cyc(); clr = 1'b0;
        ss = 1'b1; cyc(); ss = 1'b0;
        repeat (10) tick();
        lp = 1'b1; cyc(); lp = 1'b0;
        repeat (5) tick();
        chk("lap_frozen", disp(0), bcd(10));
        chk("lap_flag", lap0, 1'b1);
        lp = 1'b1; cyc(); lp = 1'b0;
        chk("lap_release", disp(0), bcd(15));

        // clear + start_stop + tick in RUN at 00:30.
        clr = 1'b1; cyc(); clr = 1'b0;
        ss = 1'b1; cyc(); ss = 1'b0;
        repeat (30) tick();
        clr = 1'b1; ss = 1'b1; c1hz = 1'b1; cyc();
        clr = 1'b0; ss = 1'b0; c1hz = 1'b0; cyc();
        chk("clr_prio_disp", disp(0), 14'd0);
        chk("clr_prio_run", run0, 1'b0);

        // start_stop + tick in RUN at 00:30.
        ss = 1'b1; cyc(); ss = 1'b0;
        repeat (30) tick();
        ss = 1'b1; c1hz = 1'b1; cyc();
        ss = 1'b0; c1hz = 1'b0; cyc();
        chk("ss_tick_disp", disp(0), bcd(31));
        chk("ss_tick_run", run0, 1'b0);

        // Roll up to 59:58 on both instances.
        clr = 1'b1; cyc(); clr = 1'b0;
        ss = 1'b1; cyc(); ss = 1'b0;
        repeat (TOP - 1) tick();
        chk("near_max0", disp(0), bcd(TOP - 1));
        chk("near_max1", disp(1), bcd(TOP - 1));
        c1hz = 1'b1; cyc();
        chk("hit0", disp(0), bcd(TOP));
        chk("hit_nomax0", max0, 1'b0);
        chk("hit1", disp(1), bcd(TOP));
        chk("hit_max1", max1, 1'b1);
        chk("hit_run1", run1, 1'b0);
        c1hz = 1'b0; cyc();
        chk("hit_max1_once", max1, 1'b0);
        c1hz = 1'b1; cyc();
        chk("wrap0", disp(0), 14'd0);
        chk("wrap_max0", max0, 1'b1);
        chk("wrap_run0", run0, 1'b1);
        chk("hold1", disp(1), bcd(TOP));
        c1hz = 1'b0; cyc();
        chk("wrap_max0_once", max0, 1'b0);
        ss = 1'b1; cyc(); ss = 1'b0;
        chk("resume_run1", run1, 1'b1);
        c1hz = 1'b1; cyc();
        chk("wrap1", disp(1), 14'd0);
        chk("wrap_max1", max1, 1'b1);
        c1hz = 1'b0; cyc();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            c1hz = 1'($urandom_range(1, 0));
            ss   = ($urandom_range(15, 0) == 0);
            lp   = ss ? 1'b0 : ($urandom_range(7, 0) == 0);
            clr  = ($urandom_range(63, 0) == 0);
            rst  = ($urandom_range(499, 0) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
